// File: rtl/spi_slave_port.sv
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) running entirely in the clk
// domain. sclk/cs_n/mosi are synchronized and edge-detected. A one-entry TX
// holding buffer feeds the TX shift register. Each completed RX word is
// presented with a single-cycle rx_valid pulse.
module spi_slave_port #(
    parameter int unsigned W           = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    input  logic [W-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    output logic         tx_underrun,
    output logic         busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Index 0 is the first synchronizer stage. Index SYNC_STAGES-1 is the synchronized
    // value. Index SYNC_STAGES is the history flop used for edge detection.
    logic [SYNC_STAGES:0]   sclk_pipe_q, sclk_pipe_d;
    logic [SYNC_STAGES:0]   cs_pipe_q, cs_pipe_d;
    logic [SYNC_STAGES-1:0] mosi_pipe_q, mosi_pipe_d;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_sync;

    state_t         state_q, state_d;
    logic [W-1:0]   tx_shift_q, tx_shift_d;
    logic [W-1:0]   rx_shift_q, rx_shift_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic           word_done_q, word_done_d;
    logic [W-1:0]   hold_q, hold_d;
    logic           hold_full_q, hold_full_d;
    logic [W-1:0]   rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           tx_underrun_q, tx_underrun_d;
    logic           reload;

    // Shift raw pins through the synchronizer chains.
    always_comb begin
        sclk_pipe_d = {sclk_pipe_q[SYNC_STAGES-1:0], sclk};
        cs_pipe_d   = {cs_pipe_q[SYNC_STAGES-1:0], cs_n};
        mosi_pipe_d = {mosi_pipe_q[SYNC_STAGES-2:0], mosi};
    end

    assign sclk_rise = sclk_pipe_q[SYNC_STAGES-1] & ~sclk_pipe_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_pipe_q[SYNC_STAGES-1] & sclk_pipe_q[SYNC_STAGES];
    assign cs_fall   = ~cs_pipe_q[SYNC_STAGES-1] & cs_pipe_q[SYNC_STAGES];
    assign cs_rise   = cs_pipe_q[SYNC_STAGES-1] & ~cs_pipe_q[SYNC_STAGES];
    assign mosi_sync = mosi_pipe_q[SYNC_STAGES-1];

    // Frame FSM, shift registers and holding-buffer bookkeeping.
    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_done_d   = word_done_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        reload        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = SHIFT;
                    reload      = 1'b1;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                end
            end
            SHIFT: begin
                // cs_rise has priority over any sclk edge seen in the same cycle.
                if (cs_rise) begin
                    state_d     = IDLE;
                    tx_shift_d  = '0;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[W-2:0], mosi_sync};
                    if (bit_cnt_q == CW'(W - 1)) begin
                        rx_data_d   = {rx_shift_q[W-2:0], mosi_sync};
                        rx_valid_d  = 1'b1;
                        bit_cnt_d   = '0;
                        word_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (word_done_q) begin
                        reload      = 1'b1;
                        word_done_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A reload checks the buffer state from before this cycle's handshake.
        // A word accepted in the same cycle therefore waits for the next word.
        if (reload) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d    = '0;
                tx_underrun_d = 1'b1;
            end
        end

        if (tx_valid && tx_ready) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_pipe_q   <= '0;
            cs_pipe_q     <= '0;
            mosi_pipe_q   <= '0;
            state_q       <= IDLE;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            word_done_q   <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            sclk_pipe_q   <= sclk_pipe_d;
            cs_pipe_q     <= cs_pipe_d;
            mosi_pipe_q   <= mosi_pipe_d;
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_done_q   <= word_done_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign tx_ready    = ~hold_full_q;
    assign busy        = (state_q == SHIFT);
    assign miso        = (state_q == SHIFT) ? tx_shift_q[W-1] : 1'b0;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Scoreboard bench for spi_slave_port. A word-level model of the holding buffer
// predicts each MISO word, each RX word and the underrun count. The bench then
// acts as the SPI master. Monitors compare what the DUT presents.
`timescale 1ns/1ps
module tb_spi_slave_port;

    localparam int W           = 32;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;   // clk cycles per sclk half period (sclk = clk/8)

    logic         clk = 1'b0;
    logic         rst, sclk, cs_n, mosi, miso;
    logic [W-1:0] tx_data, rx_data;
    logic         tx_valid, tx_ready, rx_valid, tx_underrun, busy;

    spi_slave_port #(.W(W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_rx[$];
    logic [W-1:0] exp_miso[$];
    int           exp_underrun = 0;
    int           obs_underrun = 0;

    // Word-level model of the holding buffer
    logic [W-1:0] m_hold;
    bit           m_full;
    logic [W-1:0] last_rx;

    // Frame plan shared by the model, the master and the offer process
    logic [W-1:0] mosi_w [8];
    logic [W-1:0] offer_w[8];
    bit           offer_en[8];
    int           bnd_idx;
    logic [W-1:0] bnd_w;
    int           plan_nwords;
    int           frame_bits;
    bit           frame_done;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 8; i++) begin
            offer_en[i] = 1'b0;
            offer_w[i]  = '0;
            mosi_w[i]   = '0;
        end
        bnd_idx = -1;
        bnd_w   = '0;
    endtask

    // Predict the frame word by word. Each word start takes the buffered word
    // or zero with an underrun. Offers made during a word refill the buffer.
    task automatic plan_frame(input int nwords, input int nbits);
        int starts;
        int full_words;
        logic [W-1:0] w;
        starts      = (nbits + W - 1) / W;
        full_words  = nbits / W;
        plan_nwords = nwords;
        for (int i = 0; i < starts; i++) begin
            if (m_full) w = m_hold;
            else begin
                w = '0;
                exp_underrun++;
            end
            m_full = 1'b0;
            if (i < full_words) begin
                exp_miso.push_back(w);
                exp_rx.push_back(mosi_w[i]);
                last_rx = mosi_w[i];
            end
            if (bnd_idx == i) begin
                m_hold = bnd_w;
                m_full = 1'b1;
            end
            if (i + 1 < nwords && offer_en[i+1]) begin
                m_hold = offer_w[i+1];
                m_full = 1'b1;
            end
        end
    endtask

    task automatic tx_offer(input logic [W-1:0] w);
        int t;
        t = 0;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (tx_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_offer_timeout: tx_ready %b, required 1", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_drop", W'(tx_ready), W'(0));
    endtask

    task automatic preload(input logic [W-1:0] w);
        tx_offer(w);
        m_hold = w;
        m_full = 1'b1;
    endtask

    // Offer word i a few bits into word i-1, after the buffer has been drained.
    task automatic offer_proc();
        for (int i = 1; i < plan_nwords; i++) begin
            if (offer_en[i]) begin
                wait (frame_bits >= (i - 1) * W + 4 || frame_done);
                if (!frame_done) tx_offer(offer_w[i]);
            end
        end
    endtask

    task automatic send_frame(input int nbits, input bit chk_ready);
        logic [W-1:0] cur;
        frame_bits = 0;
        frame_done = 1'b0;
        fork
            offer_proc();
        join_none
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        check("busy_in_frame", W'(busy), W'(1));
        if (chk_ready) check("tx_ready_after_cs_fall", W'(tx_ready), W'(1));
        for (int b = 0; b < nbits; b++) begin
            cur  = mosi_w[b / W];
            mosi = cur[W - 1 - (b % W)];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            frame_bits++;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            // The final falling edge and the cs_n release happen together.
            if (b == nbits - 1) cs_n = 1'b1;
            else if (((b + 1) % W == 0) && ((b + 1) / W == bnd_idx)) begin
                fork
                    begin
                        repeat (SYNC_STAGES) @(negedge clk);
                        tx_data  = bnd_w;
                        tx_valid = 1'b1;
                        @(negedge clk);
                        tx_valid = 1'b0;
                    end
                join_none
            end
        end
        mosi       = 1'b0;
        frame_done = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        check("busy_after_frame", W'(busy), W'(0));
        check("miso_idle", W'(miso), W'(0));
    endtask

    task automatic settle_checks();
        check("rx_words_outstanding", W'(exp_rx.size()), W'(0));
        check("miso_words_outstanding", W'(exp_miso.size()), W'(0));
        check("underrun_count", W'(obs_underrun), W'(exp_underrun));
    endtask

    // RX word and underrun monitor
    initial begin
        forever begin
            @(negedge clk);
            if (tx_underrun === 1'b1) obs_underrun++;
            if (rx_valid === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected: got %h, required no word", rx_data);
                end else check("rx_word", rx_data, exp_rx.pop_front());
            end
        end
    end

    // MISO monitor: samples on each sclk rise while selected, like a master would
    initial begin
        int           cnt;
        logic [W-1:0] sh;
        cnt = 0;
        sh  = '0;
        forever begin
            @(posedge sclk or posedge cs_n or posedge rst);
            if (cs_n === 1'b1 || rst === 1'b1) cnt = 0;
            else begin
                sh = {sh[W-2:0], miso};
                cnt++;
                if (cnt == W) begin
                    cnt = 0;
                    if (exp_miso.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL miso_unexpected: got %h, required no word", sh);
                    end else check("miso_word", sh, exp_miso.pop_front());
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        m_full = 1'b0; m_hold = '0; last_rx = '0;
        frame_done = 1'b1; frame_bits = 0; plan_nwords = 0;
        clear_plan();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_ready", W'(tx_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        rst = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        check("rel_tx_ready", W'(tx_ready), W'(1));
        check("rel_rx_valid", W'(rx_valid), W'(0));
        check("rel_miso", W'(miso), W'(0));
        check("rel_busy", W'(busy), W'(0));
        check("rel_rx_data", rx_data, '0);
        check("rel_underrun", W'(tx_underrun), W'(0));

        // Single word with preloaded reply
        clear_plan();
        preload(32'hA5A5_0F0F);
        mosi_w[0] = 32'h1234_5678;
        plan_frame(1, W);
        send_frame(W, 1'b1);
        settle_checks();

        // Two words, second reply supplied during word 1
        clear_plan();
        preload(32'h0000_0001);
        mosi_w[0] = $urandom; mosi_w[1] = $urandom;
        offer_en[1] = 1'b1; offer_w[1] = 32'hFFFF_FFFE;
        plan_frame(2, 2 * W);
        send_frame(2 * W, 1'b0);
        settle_checks();

        // Empty buffer: zeros on MISO, one underrun, RX still captured
        clear_plan();
        mosi_w[0] = 32'hDEAD_BEEF;
        plan_frame(1, W);
        send_frame(W, 1'b1);
        settle_checks();

        // Frame abandoned after 17 bits, then a full frame
        clear_plan();
        preload($urandom);
        mosi_w[0] = $urandom;
        plan_frame(1, 17);
        send_frame(17, 1'b0);
        check("rx_hold_after_abort", rx_data, last_rx);
        clear_plan();
        preload($urandom);
        mosi_w[0] = 32'hCAFE_F00D;
        plan_frame(1, W);
        send_frame(W, 1'b0);
        settle_checks();

        // Offer lands in the same cycle as the word-1 to word-2 reload
        clear_plan();
        preload($urandom);
        for (int i = 0; i < 3; i++) mosi_w[i] = $urandom;
        bnd_idx = 1; bnd_w = $urandom;
        plan_frame(3, 3 * W);
        send_frame(3 * W, 1'b0);
        settle_checks();

        // Randomized frames
        for (int f = 0; f < 5; f++) begin
            clear_plan();
            nw = int'($urandom_range(1, 3));
            for (int i = 0; i < nw; i++) begin
                mosi_w[i]   = $urandom;
                offer_w[i]  = $urandom;
                offer_en[i] = (i > 0) && ($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 3) != 0) preload($urandom);
            plan_frame(nw, nw * W);
            send_frame(nw * W, 1'b0);
            settle_checks();
        end

        // Asynchronous reset in the middle of a frame with a full buffer
        clear_plan();
        preload(32'hFFFF_FFFF);
        mosi_w[0] = $urandom;
        plan_frame(1, 5);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        tx_offer($urandom);
        for (int b = 0; b < 5; b++) begin
            mosi = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("mid_frame_miso", W'(miso), W'(1));
        check("mid_frame_busy", W'(busy), W'(1));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx_ready", W'(tx_ready), W'(1));
        check("async_rst_rx_valid", W'(rx_valid), W'(0));
        check("async_rst_miso", W'(miso), W'(0));
        check("async_rst_busy", W'(busy), W'(0));
        check("async_rst_rx_data", rx_data, '0);
        check("async_rst_underrun", W'(tx_underrun), W'(0));
        @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_full  = 1'b0;
        last_rx = '0;
        repeat (2 * HALF) @(negedge clk);
        check("post_rst_tx_ready", W'(tx_ready), W'(1));
        check("post_rst_busy", W'(busy), W'(0));

        // Recovery frame after reset
        clear_plan();
        preload($urandom);
        mosi_w[0] = $urandom;
        plan_frame(1, W);
        send_frame(W, 1'b1);
        settle_checks();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) and counterpart of the CPU-side SPI master register file.
- Lets a peripheral model or a second core receive words on MOSI and return words on MISO.
- Runs entirely in the clk domain: sclk, cs_n and mosi are oversampled, synchronized and edge-detected.
- Presents a one-entry TX holding buffer with valid/ready handshake and an RX word-valid pulse to local logic.

Parameters:
W, 32, word width in bits (matches CPU word)
SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi (legal range 2..3)

Ports:
clk  input  1  system clock; must run at least 4x sclk frequency
rst  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from master, idles low
cs_n  input  1  chip select, active low
mosi  input  1  master-out data
miso  output  1  slave-out data; driven 0 when deselected (no tristate)
tx_data  input  W  word to return to the master
tx_valid  input  1  tx_data offered
tx_ready  output  1  holding buffer empty; handshake completes on tx_valid&&tx_ready at posedge clk
rx_data  output  W  last complete received word
rx_valid  output  1  one-cycle pulse when rx_data updates
tx_underrun  output  1  one-cycle pulse: word boundary reached with empty buffer
busy  output  1  high while in SHIFT state

Behaviour:
- Reset (async, active-high): all outputs 0 except tx_ready=1; shift registers, bit_cnt, buffer and sync flops cleared; state=IDLE. Reset mid-frame abandons the frame; the next frame requires a fresh cs_n fall.
- Synchronization: SYNC_STAGES flops per input plus one history flop. sclk_rise/sclk_fall/cs_fall/cs_rise are single-cycle strobes from the synchronized signals. Input-to-action latency is SYNC_STAGES+1 clk cycles.
- TX buffer: on tx_valid&&tx_ready, capture tx_data and drop tx_ready the next cycle. tx_ready rises the cycle after the buffer is drained into the TX shift register.
- State machine IDLE -> SHIFT on cs_fall:
  - In the same cycle, load tx_shift from the buffer if it is full (buffer drained); otherwise load 0 and pulse tx_underrun.
  - Set bit_cnt=0.
- In SHIFT:
  - sclk_rise: rx_shift <= {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches W-1 and increments: rx_data <= completed word, rx_valid pulses the next cycle, bit_cnt wraps to 0, word_done flag set.
  - sclk_fall with word_done=0: tx_shift <= tx_shift << 1.
  - sclk_fall with word_done=1: reload tx_shift from the buffer (same full/empty rule as cs_fall, including underrun), clear word_done.
- miso = tx_shift[W-1] in SHIFT, 0 in IDLE.
- SHIFT -> IDLE on cs_rise:
  - A partial word (bit_cnt != 0) is discarded: no rx_valid, rx_data unchanged.
  - TX buffer contents are retained for the next frame; tx_shift is cleared.
- Simultaneous events:
  - tx_valid&&tx_ready in the same cycle as a reload strobe: the reload sees the buffer empty (underrun, load 0); the new word lands in the buffer for the following word.
  - cs_rise and sclk edge in the same cycle: cs_rise wins, and the edge is ignored.
  - sclk edges while in IDLE are ignored.
- rx_valid has no backpressure; an unread rx_data is simply overwritten by the next word.
- Back-to-back words within one frame are supported with no gap cycles; the MSB of word n+1 is on miso after the W-th falling edge.

Test Plan:
- Reset release -> tx_ready=1, rx_valid=0, miso=0, busy=0, rx_data=0; rst pulsed mid-frame -> same values immediately (asynchronous).
- Preload tx 0xA5A5_0F0F; master sends 0x1234_5678 in one frame (sclk = clk/8) -> master samples 0xA5A5_0F0F on MISO; rx_data=0x1234_5678 with a single rx_valid pulse; tx_ready returns to 1 after cs_fall.
- Two words in one frame; tx 0x0000_0001 preloaded and 0xFFFF_FFFE supplied during word 1 -> MISO carries 0x0000_0001 then 0xFFFF_FFFE; two rx_valid pulses; no tx_underrun.
- Frame with empty buffer -> MISO all zeros; tx_underrun pulses once at cs_fall; rx still captures the MOSI word (e.g. 0xDEAD_BEEF).
- cs_n deasserted after 17 bits -> no rx_valid, rx_data keeps its previous value; the next full frame receives 0xCAFE_F00D correctly, with bit_cnt restarted.
- tx_valid asserted in the same cycle as the word-boundary reload with an empty buffer -> tx_underrun pulse, word 2 reads 0, word 3 reads the supplied value.
